poly_stream_ctrl: RTL



---
 rtl/poly_ctrl_pkg.sv | 21 ++
 rtl/ctrl_fifo.sv | 70 +++++++
 rtl/poly_stream_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/poly_ctrl_pkg.sv
// Shared types and constants for the polynomial stream sequencer.
// Holds the controller state encoding, the address-width helper and the
// stall counter width / saturation value.
package poly_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

    // Index width for n entries; never less than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrl_fifo.sv
// First-word-fall-through FIFO holding {addr, data} results for the
// consumer. A write at cycle t is visible at the head at t+1. The head
// reads as zero while empty so the outputs stay clean after reset and
// after the last pop.
module ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_pop;

    assign o_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_FULL);
    assign w_do_pop = i_pop && !o_empty;
    assign o_rdata  = o_empty ? '0 : r_mem[r_rptr];

    // Storage array; cleared on reset so no stale entry survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Read/write pointers with explicit wrap and the occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Credits upstream make a push into a full FIFO impossible.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule

// File: rtl/poly_stream_ctrl.sv
// Sequencer for one pass of an N-coefficient polynomial through a
// fixed-latency, non-stallable pipeline. Issues are gated by a credit pool
// equal to the output FIFO depth, so results can always be absorbed.
// Optional feature: define POLY_STREAM_CTRL_STALL_CNT_EN to count RUN
// cycles lost to credit exhaustion on stall_cnt_o; otherwise it reads 0.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing coefficient reads while credits remain
// DRAIN | all issued, waiting for the last result to be popped
// DONE  | one-cycle completion pulse
module poly_stream_ctrl
    import poly_ctrl_pkg::*;
#(
    parameter int DWIDTH     = 12,
    parameter int N          = 256,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rd_en_o,
    output logic [addr_width(N)-1:0] rd_addr_o,
    input  logic [DWIDTH-1:0]        pipe_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DWIDTH-1:0]        out_data_o,
    output logic [addr_width(N)-1:0] out_addr_o,
    output logic [STALL_CNT_W-1:0]   stall_cnt_o
);

    localparam int AW = addr_width(N);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0]   N_CNT     = (AW+1)'(N);
    localparam logic [AW:0]   N_LAST    = (AW+1)'(N - 1);
    localparam logic [CW-1:0] CRED_FULL = CW'(FIFO_DEPTH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW:0]     r_issue_cnt;
    logic [AW:0]     r_ret_cnt;
    logic [CW-1:0]   r_credits;
    logic [LATENCY-1:0] r_tok_vld;
    logic [AW-1:0]   r_tok_addr [LATENCY];
    logic            w_start;
    logic            w_issue;
    logic            w_pop;
    logic            w_push;
    logic            w_fifo_empty;
    logic [AW+DWIDTH-1:0] w_fifo_rdata;

    assign w_start     = (r_state == IDLE) && start_i;
    assign w_issue     = (r_state == RUN) && (r_credits != '0);
    assign w_pop       = out_valid_o && out_ready_i;
    assign w_push      = r_tok_vld[LATENCY-1];

    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign rd_en_o     = w_issue;
    assign rd_addr_o   = r_issue_cnt[AW-1:0];
    assign out_valid_o = !w_fifo_empty;
    assign out_addr_o  = w_fifo_rdata[AW+DWIDTH-1:DWIDTH];
    assign out_data_o  = w_fifo_rdata[DWIDTH-1:0];

    // Next-state logic; DRAIN always lasts at least one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_nxt = RUN;
            RUN:     if (w_issue && (r_issue_cnt == N_LAST)) w_state_nxt = DRAIN;
            DRAIN:   if ((r_ret_cnt == N_CNT) || (w_pop && (r_ret_cnt == N_LAST))) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Issue and retire counters, restarted by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else if (w_start) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_pop)   r_ret_cnt   <= r_ret_cnt + 1'b1;
        end
    end

    // Credit pool: issue consumes, pop returns on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= CRED_FULL;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Token shift register mirroring the pipeline latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tok_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tok_addr[i] <= '0;
            end
        end else begin
            r_tok_vld[0]  <= w_issue;
            r_tok_addr[0] <= r_issue_cnt[AW-1:0];
            for (int i = 1; i < LATENCY; i++) begin
                r_tok_vld[i]  <= r_tok_vld[i-1];
                r_tok_addr[i] <= r_tok_addr[i-1];
            end
        end
    end

    ctrl_fifo #(
        .WIDTH (AW + DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({r_tok_addr[LATENCY-1], pipe_data_i}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty)
    );

`ifdef POLY_STREAM_CTRL_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Count RUN cycles with no credit; saturating, held outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start) begin
            r_stall_cnt <= '0;
        end else if ((r_state == RUN) && (r_credits == '0) && (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
